// File: rtl/pipeline_pkg.sv
// Shared opcodes, instruction type field codes and memory-stage FSM states.
package pipeline_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;

    // Opcode bit 15 selects the instruction format.
    typedef enum logic {
        R_TYPE = 1'b0,
        A_TYPE = 1'b1
    } type_field_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_A,
        CLS_LOAD,
        CLS_STORE
    } instr_class_t;

    function automatic instr_class_t classify(input logic [3:0] opcode);
        instr_class_t cls;
        if (opcode == OP_LOAD) begin
            cls = CLS_LOAD;
        end else if (opcode == OP_STORE) begin
            cls = CLS_STORE;
        end else if (type_field_t'(opcode[3]) == R_TYPE) begin
            cls = CLS_R;
        end else begin
            cls = CLS_A;
        end
        return cls;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles that end without mem_ready; only built with PIPELINE_MEMORY_TIMEOUT_EN.
`ifdef PIPELINE_MEMORY_TIMEOUT_EN
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry lands on the edge that closes the TIMEOUT_CYCLES-th waiting cycle.
    assign o_expired = i_count && (r_count == LAST);

endmodule
`endif

// File: rtl/pipeline_memory.sv
// Memory stage: forwards ALU results and performs load/store accesses to data memory.
// Defining PIPELINE_MEMORY_TIMEOUT_EN adds an abort when an access waits TIMEOUT_CYCLES cycles.
module pipeline_memory
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_done,
    input  logic        execute_is_dependent,
    input  logic [15:0] execute_result,
    input  logic [15:0] execute_instr,
    input  logic [15:0] execute_store_data,
    output logic        memory_stall,
    output logic        memory_done,
    output logic        memory_is_dependent,
    output logic [15:0] memory_result,
    output logic [15:0] memory_instr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        memory_fault
);

    mem_state_t   r_state;
    logic         r_done;
    logic         r_isDependent;
    logic [15:0]  r_result;
    logic [15:0]  r_instr;
    logic         r_req;
    logic         r_we;
    logic [15:0]  r_addr;
    logic [15:0]  r_wdata;
    logic [15:0]  r_latchedInstr;
    logic         r_isLoad;
    logic         r_fault;

    instr_class_t w_class;
    logic         w_isLoad;
    logic         w_isStore;
    logic         w_timeout;

    assign w_class   = classify(execute_instr[15:12]);
    assign w_isLoad  = (w_class == CLS_LOAD);
    assign w_isStore = (w_class == CLS_STORE);

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
    logic w_clearTimer;
    logic w_countTimer;

    assign w_clearTimer = (r_state == IDLE);
    assign w_countTimer = (r_state == ACCESS) && !mem_ready;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clearTimer),
        .i_count  (w_countTimer),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_done         <= 1'b0;
            r_isDependent  <= 1'b0;
            r_result       <= '0;
            r_instr        <= '0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_latchedInstr <= '0;
            r_isLoad       <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_isLoad || w_isStore) begin
                        // Stage outputs become a bubble while the access is outstanding.
                        r_state        <= ACCESS;
                        r_req          <= 1'b1;
                        r_we           <= w_isStore;
                        r_addr         <= execute_result;
                        r_wdata        <= w_isStore ? execute_store_data : 16'h0000;
                        r_latchedInstr <= execute_instr;
                        r_isLoad       <= w_isLoad;
                        r_done         <= 1'b0;
                        r_isDependent  <= 1'b0;
                        r_result       <= '0;
                        r_instr        <= '0;
                    end else begin
                        r_done        <= execute_done;
                        r_isDependent <= execute_is_dependent;
                        r_result      <= execute_result;
                        r_instr       <= execute_instr;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        r_state       <= IDLE;
                        r_req         <= 1'b0;
                        r_we          <= 1'b0;
                        r_addr        <= '0;
                        r_wdata       <= '0;
                        r_done        <= 1'b1;
                        r_isDependent <= r_isLoad;
                        r_result      <= r_isLoad ? mem_rdata : r_addr;
                        r_instr       <= r_latchedInstr;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_fault <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign memory_stall        = (r_state == ACCESS) && !mem_ready;
    assign memory_done         = r_done;
    assign memory_is_dependent = r_isDependent;
    assign memory_result       = r_result;
    assign memory_instr        = r_instr;
    assign mem_req             = r_req;
    assign mem_we              = r_we;
    assign mem_addr            = r_addr;
    assign mem_wdata           = r_wdata;
    assign memory_fault        = r_fault;

endmodule

// File: tb/tb_pipeline_memory.sv
// Scoreboard bench for pipeline_memory; the abort scenario runs when PIPELINE_MEMORY_TIMEOUT_EN is defined.
module tb_pipeline_memory;

    logic        clk;
    logic        reset;
    logic        execute_done;
    logic        execute_is_dependent;
    logic [15:0] execute_result;
    logic [15:0] execute_instr;
    logic [15:0] execute_store_data;
    logic        memory_stall;
    logic        memory_done;
    logic        memory_is_dependent;
    logic [15:0] memory_result;
    logic [15:0] memory_instr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        memory_fault;

    typedef struct packed {
        logic        dependent;
        logic [15:0] result;
        logic [15:0] instr;
    } expect_t;

    expect_t expQueue[$];
    expect_t monExp;
    int      compared   = 0;
    int      mismatched = 0;

    pipeline_memory #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .execute_done        (execute_done),
        .execute_is_dependent(execute_is_dependent),
        .execute_result      (execute_result),
        .execute_instr       (execute_instr),
        .execute_store_data  (execute_store_data),
        .memory_stall        (memory_stall),
        .memory_done         (memory_done),
        .memory_is_dependent (memory_is_dependent),
        .memory_result       (memory_result),
        .memory_instr        (memory_instr),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ready           (mem_ready),
        .mem_rdata           (mem_rdata),
        .memory_fault        (memory_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Completed instructions are popped and compared in the middle of the cycle they appear.
    always @(negedge clk) begin
        if (reset && memory_done) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpectedDone", 32'(expQueue.size()), 32'd1);
            end else begin
                monExp = expQueue.pop_front();
                checkOutput("sbDependent", memory_is_dependent, monExp.dependent);
                checkOutput("sbResult", memory_result, monExp.result);
                checkOutput("sbInstr", memory_instr, monExp.instr);
            end
        end
    end

    task automatic idleExecute();
        execute_done         = 1'b0;
        execute_is_dependent = 1'b0;
        execute_result       = 16'h0000;
        execute_instr        = 16'h0000;
        execute_store_data   = 16'h0000;
    endtask

    // Pass-through instruction, entered one time unit after a rising edge.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] result, input logic dependent);
        execute_done         = 1'b1;
        execute_is_dependent = dependent;
        execute_result       = result;
        execute_instr        = instr;
        execute_store_data   = 16'hFFFF;
        expQueue.push_back('{dependent: dependent, result: result, instr: instr});
        #1;
        checkOutput("passStall", memory_stall, 1'b0);
        @(posedge clk);
        #1;
        idleExecute();
        checkOutput("passNoReq", mem_req, 1'b0);
    endtask

    task automatic applyMemAccess(input logic isStore, input logic [15:0] addr, input logic [15:0] data,
                                  input int waitCycles, input logic [2:0] rd, input logic [15:0] rdata);
        logic [15:0] instr;
        int          stalls;
        instr = {(isStore ? 4'b1001 : 4'b1000), 9'h000, rd};
        execute_done         = 1'b1;
        execute_is_dependent = !isStore;
        execute_result       = addr;
        execute_instr        = instr;
        execute_store_data   = data;
        #1;
        checkOutput("idleStall", memory_stall, 1'b0);
        @(posedge clk);
        #1;
        idleExecute();
        checkOutput("accReq", mem_req, 1'b1);
        checkOutput("accAddr", mem_addr, addr);
        checkOutput("accWe", mem_we, isStore);
        checkOutput("accWdata", mem_wdata, isStore ? data : 16'h0000);
        checkOutput("bubbleDone", memory_done, 1'b0);
        checkOutput("bubbleDep", memory_is_dependent, 1'b0);
        checkOutput("bubbleResult", memory_result, 16'h0000);
        checkOutput("bubbleInstr", memory_instr, 16'h0000);
        stalls = 0;
        for (int i = 0; i < waitCycles; i++) begin
            #1;
            if (memory_stall) stalls++;
            @(posedge clk);
            #1;
            checkOutput("holdReq", mem_req, 1'b1);
            checkOutput("holdAddr", mem_addr, addr);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        expQueue.push_back('{dependent: !isStore, result: (isStore ? addr : rdata), instr: instr});
        #1;
        checkOutput("readyStall", memory_stall, 1'b0);
        checkOutput("stallCycles", 32'(stalls), 32'(waitCycles));
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = 16'h5A5A;
        checkOutput("doneReqLow", mem_req, 1'b0);
        checkOutput("doneWeLow", mem_we, 1'b0);
        checkOutput("doneStall", memory_stall, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation ran out of time, queue depth %0d, expected 0", expQueue.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        idleExecute();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReq", mem_req, 1'b0);
        checkOutput("rstDone", memory_done, 1'b0);
        checkOutput("rstResult", memory_result, 16'h0000);
        checkOutput("rstStall", memory_stall, 1'b0);
        checkOutput("rstFault", memory_fault, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] pass-through instructions");
        applyStimulus(16'h2AB3, 16'h00A5, 1'b1);
        applyStimulus(16'hF00F, 16'h1234, 1'b0);
        mem_ready = 1'b1;
        applyStimulus(16'hA005, 16'hCAFE, 1'b1);
        mem_ready = 1'b0;

        $display("[TB] load with three wait cycles");
        applyMemAccess(1'b0, 16'h0040, 16'h5555, 3, 3'd5, 16'hBEEF);

        $display("[TB] store completing on first cycle");
        applyMemAccess(1'b1, 16'h0010, 16'h1234, 0, 3'd0, 16'hDEAD);

        $display("[TB] reset during access");
        execute_done   = 1'b1;
        execute_instr  = 16'h8002;
        execute_result = 16'h0080;
        @(posedge clk);
        #1;
        idleExecute();
        checkOutput("abortReqBefore", mem_req, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("abortReq", mem_req, 1'b0);
        checkOutput("abortDone", memory_done, 1'b0);
        checkOutput("abortStall", memory_stall, 1'b0);
        checkOutput("abortAddr", mem_addr, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("abortDoneLater", memory_done, 1'b0);
        applyMemAccess(1'b0, 16'h0082, 16'h0000, 1, 3'd2, 16'h0F0F);

        $display("[TB] back-to-back loads");
        applyMemAccess(1'b0, 16'h0100, 16'h0000, 2, 3'd1, 16'h1111);
        applyMemAccess(1'b0, 16'h0102, 16'h0000, 0, 3'd4, 16'h2222);
        applyStimulus(16'h0007, 16'h0077, 1'b1);

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
        $display("[TB] access timeout");
        execute_done   = 1'b1;
        execute_instr  = 16'h8006;
        execute_result = 16'h0200;
        @(posedge clk);
        #1;
        idleExecute();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("toWaitFault", memory_fault, 1'b0);
            checkOutput("toWaitReq", mem_req, 1'b1);
        end
        @(posedge clk);
        #1;
        checkOutput("toFault", memory_fault, 1'b1);
        checkOutput("toReq", mem_req, 1'b0);
        checkOutput("toStall", memory_stall, 1'b0);
        checkOutput("toDone", memory_done, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("toFaultPulse", memory_fault, 1'b0);
        applyMemAccess(1'b0, 16'h0204, 16'h0000, 3, 3'd6, 16'h7E57);
`else
        checkOutput("noFault", memory_fault, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sbEmpty", 32'(expQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
